// File: rtl/ahb_slave_responder_pkg.sv
// ahb_slave_responder_pkg: shared AHB encodings and responder state type
package ahb_slave_responder_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;
  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;
  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LAST = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;
  function automatic logic is_active(input logic [1:0] t);
    return t == HTRANS_NONSEQ || t == HTRANS_SEQ;
  endfunction
endpackage

// File: rtl/ahb_slave_byte_ram.sv
// ahb_slave_byte_ram: sync-write, async-read word array with per-byte write enables
module ahb_slave_byte_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IW         = 8
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [IW-1:0]           idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  // commit only the byte lanes whose enable is set
  always_ff @(posedge clk)
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/ahb_slave_responder.sv
// ahb_slave_responder: memory-backed AHB slave data-phase engine with programmable wait states
module ahb_slave_responder
  import ahb_slave_responder_pkg::*;
#(
  parameter int                      ADDR_WIDTH = 32,
  parameter int                      DATA_WIDTH = 32,
  parameter int                      MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  input  logic [3:0]              wait_cfg,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hexokay
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int LB = $clog2(BW);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(MEM_DEPTH * BW);
  state_e          state_q, state_d, acc_state;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d, idx_a;
  logic            write_q, write_d;
  logic            hreadyout_q, hreadyout_d;
  logic            hresp_q, hresp_d;
  logic [ADDR_WIDTH-1:0] off;
  logic            err_a, acc;
  logic [BW-1:0]   we;
  logic [DATA_WIDTH-1:0] rdata;
  logic            unused_ok;
  assign off   = haddr - BASE_ADDR;
  assign err_a = haddr < BASE_ADDR || {1'b0, off} >= SPAN || hsize > 3'(LB);
  assign idx_a = off[LB +: IW];
  assign unused_ok = ^{hburst, hprot};
  // address-phase decode, next state and the registered response for the coming cycle
  always_comb begin
    acc         = (state_q inside {S_IDLE, S_LAST, S_ERR2}) && hselx && hready && is_active(htrans);
    acc_state   = err_a ? S_ERR1 : wait_cfg != 4'd0 ? S_WAIT : S_LAST;
    state_d     = state_q == S_WAIT ? (cnt_q == 4'd1 ? S_LAST : S_WAIT) :
                  state_q == S_ERR1 ? S_ERR2 : acc ? acc_state : S_IDLE;
    cnt_d       = state_q == S_WAIT ? cnt_q - 4'd1 : acc ? wait_cfg : cnt_q;
    idx_d       = acc ? idx_a : idx_q;
    write_d     = acc ? hwrite : write_q;
    hreadyout_d = !(state_d inside {S_WAIT, S_ERR1});
    hresp_d     = state_d inside {S_ERR1, S_ERR2};
    we          = state_q == S_LAST && write_q && !hreset ? hwstrb : '0;
  end
  // state and response registers; reset drops any pending data phase
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end
  ahb_slave_byte_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IW        (IW)
  ) u_ram (
    .clk  (hclk),
    .we   (we),
    .idx  (idx_q),
    .wdata(hwdata),
    .rdata(rdata)
  );
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = state_q == S_LAST && !write_q ? rdata : '0;
  assign hexokay   = 1'b0;
endmodule

// File: tb/tb_ahb_slave_responder.sv
// tb_ahb_slave_responder: randomized check of the responder against a word-array reference model
module tb_ahb_slave_responder;
  logic        hclk = 1'b0, hreset = 1'b1, hselx = 1'b0, hwrite = 1'b0, hready = 1'b1;
  logic [31:0] haddr = '0, hwdata = '0, hrdata;
  logic [1:0]  htrans = 2'd0;
  logic [2:0]  hsize = 3'd2, hburst = 3'd0;
  logic [3:0]  hprot = '0, hwstrb = '0, wait_cfg = '0;
  logic        hreadyout, hresp, hexokay;
  logic [31:0] mdl [256];
  int          n_tests = 0, n_fail = 0;

  ahb_slave_responder dut (
    .hclk(hclk), .hreset(hreset), .hselx(hselx), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hwstrb(hwstrb), .hready(hready), .wait_cfg(wait_cfg), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .hexokay(hexokay)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_bus;
    hselx = 1'b0; htrans = 2'd0; hwrite = 1'b0; hready = 1'b1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, input logic [3:0] st, input logic [3:0] w);
    logic err;
    int   lows;
    err = a >= 32'h400 || sz > 3'd2;
    check("idle_rdy", hreadyout, 1);
    hselx = 1'b1; htrans = 2'd2; hwrite = wr; haddr = a; hsize = sz; wait_cfg = w;
    hburst = 3'($urandom); hprot = 4'($urandom);
    tick;
    idle_bus;
    hwdata = d; hwstrb = st; wait_cfg = 4'($urandom); haddr = $urandom;
    lows = 0;
    while (hreadyout === 1'b0 && lows < 40) begin
      check("wait_resp", hresp, err);
      check("wait_rdata", hrdata, 0);
      lows++;
      tick;
    end
    check("wait_cycles", lows, err ? 1 : int'(w));
    check("last_resp", hresp, err);
    check("last_rdata", hrdata, (!err && !wr) ? mdl[a[9:2]] : 32'h0);
    check("hexokay", hexokay, 0);
    if (!err && wr) mdl[a[9:2]] = merge(mdl[a[9:2]], d, st);
    tick;
  endtask

  task automatic probe(input int kind, input logic [31:0] a, input logic wr);
    hwrite = wr; haddr = a; hsize = 3'd2; hwdata = $urandom; hwstrb = 4'hF;
    if (kind == 0) begin hselx = 1'b1; htrans = 2'd1; end
    else if (kind == 1) begin hselx = 1'b0; htrans = 2'd2; end
    else begin hselx = 1'b1; htrans = 2'd2; hready = 1'b0; end
    tick;
    idle_bus;
    check("probe_rdy", hreadyout, 1);
    check("probe_resp", hresp, 0);
    check("probe_rdata", hrdata, 0);
    tick;
    xfer(1'b0, a, 3'd2, 32'h0, 4'h0, 4'd0);
  endtask

  task automatic raw_pair(input logic [31:0] a, input logic [31:0] d);
    hselx = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = a; hsize = 3'd2; wait_cfg = 4'd0;
    tick;
    hwdata = d; hwstrb = 4'hF; hwrite = 1'b0;
    check("raw_wlast_rdy", hreadyout, 1);
    mdl[a[9:2]] = d;
    tick;
    idle_bus;
    check("raw_rdy", hreadyout, 1);
    check("raw_rdata", hrdata, d);
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick;
    check("rst_rdy", hreadyout, 1);
    check("rst_resp", hresp, 0);
    check("rst_rdata", hrdata, 0);
    check("rst_exokay", hexokay, 0);
    hreset = 1'b0;
    tick;
    for (int i = 0; i < 256; i++) xfer(1'b1, 32'(i * 4), 3'd2, $urandom, 4'hF, 4'd0);
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF, 4'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, 4'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, 4'd3);
    xfer(1'b1, 32'h400, 3'd2, 32'h12345678, 4'hF, 4'd2);
    xfer(1'b0, 32'h0, 3'd2, 32'h0, 4'h0, 4'd0);
    xfer(1'b0, 32'h10, 3'd3, 32'h0, 4'h0, 4'd4);
    xfer(1'b1, 32'h20, 3'd2, 32'hAAAAAAAA, 4'hF, 4'd1);
    xfer(1'b1, 32'h20, 3'd2, 32'h11223344, 4'h3, 4'd0);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, 4'h0, 4'd0);
    check("partial_model", mdl[8], 32'hAAAA3344);
    probe(0, 32'h10, 1'b0);
    probe(1, 32'h20, 1'b1);
    probe(2, 32'h24, 1'b0);
    hselx = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2; wait_cfg = 4'd5;
    tick;
    idle_bus; hwdata = 32'h55; hwstrb = 4'hF;
    check("rstw_wait1", hreadyout, 0);
    tick;
    check("rstw_wait2", hreadyout, 0);
    hreset = 1'b1;
    tick;
    hreset = 1'b0;
    check("rstw_rdy", hreadyout, 1);
    check("rstw_resp", hresp, 0);
    check("rstw_rdata", hrdata, 0);
    xfer(1'b0, 32'h30, 3'd2, 32'h0, 4'h0, 4'd0);
    for (int i = 0; i < 4; i++) raw_pair(32'($urandom_range(0, 255) * 4), $urandom);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 2)
        probe(int'($urandom_range(0, 2)), 32'($urandom_range(0, 255) * 4), 1'($urandom));
      else
        xfer(1'($urandom), 32'($urandom_range(0, 32'h47F)),
             $urandom_range(0, 9) == 0 ? 3'd3 : 3'($urandom_range(0, 2)),
             $urandom, 4'($urandom), 4'($urandom_range(0, 6)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_slave_responder.md
Name: ahb_slave_responder

Overview:
- Memory-backed AHB slave data-phase engine: captures address phases, inserts programmable wait states, and commits or returns data.
- Drives the response side that the slave assertion interface checks: hreadyout, hresp, hrdata and hexokay.
- Sits directly behind the decoder: consumes hselx plus the address/control bus and produces the slave response bus.
- Used as the DUT-side slave model in the AHB AVIP and as a reusable on-chip RAM slave.

Parameters:
- ADDR_WIDTH, 32: haddr width.
- DATA_WIDTH, 32: hrdata/hwdata width. Legal values are 32 and 64.
- MEM_DEPTH, 256: number of DATA_WIDTH words of internal storage.
- BASE_ADDR, 0: byte address of word 0.

Ports:
- hclk  in  1  clock.
- hreset  in  1  reset. Synchronous, active-high.
- hselx  in  1  slave select.
- haddr  in  ADDR_WIDTH  address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hburst  in  3  burst type. Informational only.
- hprot  in  4  protection. Ignored.
- hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- hwstrb  in  DATA_WIDTH/8  byte strobes, valid in the data phase.
- hready  in  1  bus-level ready (mux output).
- wait_cfg  in  4  wait states inserted per OKAY transfer.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_WIDTH  read data.
- hexokay  out  1  always 0 (no exclusive support).

Behaviour:
- Reset: synchronous, active-high.
  - While hreset is high: state=S_IDLE, hreadyout=1, hresp=0, hrdata=0, hexokay=0, wait counter=0, pending phase discarded.
  - Memory contents are not cleared.
- Accept condition: hselx && hready && htrans[1] (NONSEQ or SEQ). On accept, latch into registers: addr, write, size, word index, err flag, waits=wait_cfg.
- err flag is set when either:
  - the address is outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8), or
  - hsize > log2(DATA_WIDTH/8).
- IDLE or BUSY while selected, or any cycle not selected: no data phase is created. Zero-wait OKAY.
- States:
  - S_IDLE: hreadyout=1, hresp=0.
    - Accept with err -> S_ERR1.
    - Accept with waits>0 -> S_WAIT (counter=waits).
    - Accept with waits=0 -> S_LAST.
  - S_WAIT: hreadyout=0, hresp=0. Decrement counter each cycle. Counter==1 -> S_LAST.
  - S_LAST: hreadyout=1, hresp=0. This is the final data-phase cycle.
    - Read: hrdata = mem[idx].
    - Write: mem[idx] byte lanes where hwstrb=1 are written from hwdata at the clock edge ending this cycle.
    - Same cycle may accept the next address: next state follows the S_IDLE rules. No accept -> S_IDLE.
  - S_ERR1: hreadyout=0, hresp=1. -> S_ERR2 unconditionally.
  - S_ERR2: hreadyout=1, hresp=1. No memory access. Accept rules as S_IDLE apply.
- Latency:
  - OKAY transfer occupies 1+wait_cfg data-phase cycles.
  - ERROR always occupies exactly 2 cycles, independent of wait_cfg.
- hrdata is 0 outside an S_LAST read cycle.
- hresp holds 0 in every cycle except S_ERR1/S_ERR2.
- wait_cfg is sampled only at accept. Changes during a data phase do not affect that transfer.
- hready low from another slave (hreadyout high, no pending phase): no accept. State unchanged.
- Read-after-write to the same word in back-to-back transfers returns the new data. The write commits at the end of S_LAST, before the read's S_LAST.
- Reset asserted in S_WAIT or S_ERR1: the transfer is aborted and no write is committed. hreadyout=1 in the cycle after reset is sampled.
- Sub-word writes rely on hwstrb only. hsize/haddr lanes are not re-derived.

Decomposition:
- Shared package (existing AhbGlobalPackage) holds:
  - htrans enum (IDLE/BUSY/NONSEQ/SEQ).
  - hresp enum (OKAY/ERROR).
  - hsize enum.
  - Responder state enum (S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2).
- One natural sub-module: ahb_slave_byte_ram.
  - Synchronous-write, asynchronous-read array of MEM_DEPTH words.
  - Per-byte write enables.
- FSM, address-phase capture and decode stay in the top.

Test Plan:
- Zero-wait write then read:
  - Stimulus: wait_cfg=0; NONSEQ write addr 0x10 data 0xDEADBEEF hwstrb=0xF; then NONSEQ read 0x10.
  - Response: hreadyout stays 1; read data phase shows hrdata=0xDEADBEEF, hresp=0.
- Wait states:
  - Stimulus: wait_cfg=3, NONSEQ read 0x10.
  - Response: hreadyout=0 for exactly 3 cycles, then 1 with hrdata=0xDEADBEEF.
- Out-of-range error:
  - Stimulus: NONSEQ write to 0x400 (MEM_DEPTH=256, DATA_WIDTH=32).
  - Response: cycle1 hreadyout=0/hresp=1; cycle2 hreadyout=1/hresp=1; memory unchanged.
  - Also: hsize=3 on a 32-bit bus gives the same 2-cycle ERROR.
- Partial write:
  - Stimulus: write 0x11223344 to 0x20 with hwstrb=0x3 over prior 0xAAAAAAAA.
  - Response: readback 0xAAAA3344.
- BUSY/IDLE/unselected:
  - Stimulus: htrans=BUSY with hselx=1; separately NONSEQ with hselx=0.
  - Response: hreadyout=1, hresp=0, no memory change.
- Reset mid-wait:
  - Stimulus: wait_cfg=5 write to 0x30 data 0x55; assert hreset in the 2nd wait cycle.
  - Response: next cycle hreadyout=1, hresp=0, hrdata=0; readback of 0x30 is the pre-write value.
